// File: rtl/tau_pkg.sv
// Shared types for the ALU write-back path: register indices and the buffered
// result entry.
package tau_pkg;

    localparam int unsigned WORD_SIZE = 8;

    typedef logic [2:0] reg_idx_t;

    localparam reg_idx_t REG_A = 3'd0;
    localparam reg_idx_t REG_B = 3'd1;
    localparam reg_idx_t REG_C = 3'd2;
    localparam reg_idx_t REG_D = 3'd3;
    localparam reg_idx_t REG_E = 3'd4;
    localparam reg_idx_t REG_F = 3'd5;
    localparam reg_idx_t REG_G = 3'd6;
    localparam reg_idx_t REG_H = 3'd7;

    typedef struct packed {
        reg_idx_t               dest;
        logic [WORD_SIZE-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back entries. Full/empty are derived from the
// occupancy count; the entry array and valid mask are exposed for pending decode.
module wb_fifo
    import tau_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  wb_entry_t       wr_entry,
    input  logic            pop,
    input  logic            flush,
    output wb_entry_t       rd_entry,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty,
    output wb_entry_t       entries [DEPTH],
    output logic [DEPTH-1:0] valid
);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;
    logic [PW-1:0]   offs [DEPTH];

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // Power-of-two depth: pointers wrap by natural overflow.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: stale slots are masked by the count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wr_entry;
    end

    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs[i]  = PW'(i) - rd_ptr_q;
            valid[i] = ({1'b0, offs[i]} < count_q);
        end
    end

    assign rd_entry = mem[rd_ptr_q];
    assign entries  = mem;
    assign count    = count_q;

endmodule

// File: rtl/regfile_writeback.sv
// Write-back stage: buffers ALU results and retires one per cycle into the
// eight general registers A..H, flagging registers with uncommitted writes.
module regfile_writeback
    import tau_pkg::*;
#(
    parameter int unsigned WORD_SIZE = tau_pkg::WORD_SIZE,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wb_valid,
    output logic                        wb_ready,
    input  logic [2:0]                  wb_dest,
    input  logic [WORD_SIZE-1:0]        wb_data,
    input  logic                        commit_en,
    input  logic                        flush,
    output logic [WORD_SIZE-1:0]        A,
    output logic [WORD_SIZE-1:0]        B,
    output logic [WORD_SIZE-1:0]        C,
    output logic [WORD_SIZE-1:0]        D,
    output logic [WORD_SIZE-1:0]        E,
    output logic [WORD_SIZE-1:0]        F,
    output logic [WORD_SIZE-1:0]        G,
    output logic [WORD_SIZE-1:0]        H,
    output logic [7:0]                  pending,
    output logic [$clog2(DEPTH):0]      count
);

    wb_entry_t              wr_entry, rd_entry;
    wb_entry_t              entries [DEPTH];
    logic [DEPTH-1:0]       valid;
    logic                   full, empty;
    logic                   push, commit;
    logic [WORD_SIZE-1:0]   regs_q [8];

    assign wb_ready      = !rst && !flush && !full;
    assign push          = wb_valid && wb_ready;
    assign commit        = commit_en && !empty && !flush;
    assign wr_entry.dest = wb_dest;
    assign wr_entry.data = wb_data;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (commit),
        .flush    (flush),
        .rd_entry (rd_entry),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .entries  (entries),
        .valid    (valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else if (commit) begin
            regs_q[rd_entry.dest] <= rd_entry.data;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) pending[entries[i].dest] = 1'b1;
        end
    end

    assign A = regs_q[REG_A];
    assign B = regs_q[REG_B];
    assign C = regs_q[REG_C];
    assign D = regs_q[REG_D];
    assign E = regs_q[REG_E];
    assign F = regs_q[REG_F];
    assign G = regs_q[REG_G];
    assign H = regs_q[REG_H];

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: reset, single write, back-pressure,
// ordering, streaming with pointer wrap, and flush.
module tb_regfile_writeback;

    logic       clk = 1'b0;
    logic       rst;
    logic       wb_valid, wb_ready, commit_en, flush;
    logic [2:0] wb_dest;
    logic [7:0] wb_data;
    logic [7:0] A, B, C, D, E, F, G, H;
    logic [7:0] pending;
    logic [2:0] count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_r [8];

    typedef struct {
        logic [2:0] d;
        logic [7:0] v;
    } ent_t;
    ent_t q[$];

    regfile_writeback #(
        .WORD_SIZE (8),
        .DEPTH     (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data),
        .commit_en (commit_en),
        .flush     (flush),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .E         (E),
        .F         (F),
        .G         (G),
        .H         (H),
        .pending   (pending),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] reg_at(int i);
        case (i)
            0: return A;
            1: return B;
            2: return C;
            3: return D;
            4: return E;
            5: return F;
            6: return G;
            default: return H;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Commit A=0x55, then buffer two entries before a mid-cycle reset.
        commit_en = 1'b1; wb_valid = 1'b1; wb_dest = 3'd0; wb_data = 8'h55;
        tick();
        wb_valid = 1'b0;
        tick();
        n_cmp++;
        if (A !== 8'h55) begin
            n_err++; $display("FAIL reset_pre_a: got %h expected 55", A);
        end
        commit_en = 1'b0; wb_valid = 1'b1;
        wb_dest = 3'd1; wb_data = 8'h10;
        tick();
        wb_dest = 3'd2; wb_data = 8'h20;
        tick();
        wb_valid = 1'b0;
        n_cmp++;
        if (count !== 3'd2 || pending !== 8'h06) begin
            n_err++; $display("FAIL reset_pre_buf: count %0d pending %h expected 2 06", count, pending);
        end
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_r[i] = 8'h00;
            n_cmp++;
            if (reg_at(i) !== 8'h00) begin
                n_err++; $display("FAIL reset_reg%0d: got %h expected 00", i, reg_at(i));
            end
        end
        n_cmp++;
        if (count !== 3'd0 || pending !== 8'h00 || wb_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_state: count %0d pending %h ready %b expected 0 00 0",
                              count, pending, wb_ready);
        end
        tick();
        n_cmp++;
        if (wb_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready_held: got %b expected 0", wb_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (wb_ready !== 1'b1 || count !== 3'd0) begin
            n_err++; $display("FAIL reset_release: ready %b count %0d expected 1 0", wb_ready, count);
        end
    endtask

    task automatic test_single();
        tick();
        commit_en = 1'b1; wb_valid = 1'b1; wb_dest = 3'd3; wb_data = 8'hA7;
        tick();
        wb_valid = 1'b0;
        n_cmp++;
        if (pending !== 8'h08 || count !== 3'd1 || D !== 8'h00) begin
            n_err++; $display("FAIL single_pend: pending %h count %0d D %h expected 08 1 00",
                              pending, count, D);
        end
        tick();
        exp_r[3] = 8'hA7;
        n_cmp++;
        if (D !== 8'hA7 || pending !== 8'h00 || count !== 3'd0) begin
            n_err++; $display("FAIL single_commit: D %h pending %h count %0d expected a7 00 0",
                              D, pending, count);
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] dt [4] = '{3'd0, 3'd1, 3'd2, 3'd7};
        logic [7:0] vt [4] = '{8'h11, 8'h22, 8'h33, 8'h77};
        commit_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; wb_dest = dt[i]; wb_data = vt[i];
            tick();
        end
        n_cmp++;
        if (count !== 3'd4 || wb_ready !== 1'b0 || pending !== 8'h87) begin
            n_err++; $display("FAIL bp_full: count %0d ready %b pending %h expected 4 0 87",
                              count, wb_ready, pending);
        end
        wb_dest = 3'd4; wb_data = 8'h99;
        tick();
        n_cmp++;
        if (count !== 3'd4 || pending !== 8'h87) begin
            n_err++; $display("FAIL bp_fifth: count %0d pending %h expected 4 87", count, pending);
        end
        wb_valid = 1'b0; commit_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_r[dt[i]] = vt[i];
            n_cmp++;
            if (reg_at(int'(dt[i])) !== vt[i] || count !== 3'(3 - i) || wb_ready !== 1'b1) begin
                n_err++; $display("FAIL bp_drain%0d: reg %h count %0d ready %b expected %h %0d 1",
                                  i, reg_at(int'(dt[i])), count, wb_ready, vt[i], 3 - i);
            end
        end
        n_cmp++;
        if (E !== 8'h00 || pending !== 8'h00) begin
            n_err++; $display("FAIL bp_dropped: E %h pending %h expected 00 00", E, pending);
        end
    endtask

    task automatic test_same_dest();
        commit_en = 1'b1; wb_valid = 1'b1; wb_dest = 3'd5; wb_data = 8'h01;
        tick();
        wb_data = 8'h02;
        tick();
        wb_valid = 1'b0;
        n_cmp++;
        if (F !== 8'h01 || pending !== 8'h20 || count !== 3'd1) begin
            n_err++; $display("FAIL same_first: F %h pending %h count %0d expected 01 20 1",
                              F, pending, count);
        end
        tick();
        exp_r[5] = 8'h02;
        n_cmp++;
        if (F !== 8'h02 || pending !== 8'h00) begin
            n_err++; $display("FAIL same_second: F %h pending %h expected 02 00", F, pending);
        end
    endtask

    task automatic test_back_to_back();
        ent_t e;
        commit_en = 1'b0; wb_valid = 1'b1;
        wb_dest = 3'd0; wb_data = 8'hB0; q.push_back('{3'd0, 8'hB0});
        tick();
        wb_dest = 3'd1; wb_data = 8'hB1; q.push_back('{3'd1, 8'hB1});
        tick();
        commit_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wb_dest = 3'((i + 3) % 8); wb_data = 8'hC0 + 8'(i);
            q.push_back('{wb_dest, wb_data});
            tick();
            e = q.pop_front();
            exp_r[e.d] = e.v;
            n_cmp++;
            if (reg_at(int'(e.d)) !== e.v || count !== 3'd2) begin
                n_err++; $display("FAIL b2b_%0d: reg%0d %h count %0d expected %h 2",
                                  i, e.d, reg_at(int'(e.d)), count, e.v);
            end
        end
        wb_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = q.pop_front();
            exp_r[e.d] = e.v;
            n_cmp++;
            if (reg_at(int'(e.d)) !== e.v || count !== 3'(1 - i)) begin
                n_err++; $display("FAIL b2b_drain%0d: reg%0d %h count %0d expected %h %0d",
                                  i, e.d, reg_at(int'(e.d)), count, e.v, 1 - i);
            end
        end
    endtask

    task automatic test_flush();
        commit_en = 1'b0; wb_valid = 1'b1;
        wb_dest = 3'd4; wb_data = 8'h44; tick();
        wb_dest = 3'd6; wb_data = 8'h66; tick();
        wb_dest = 3'd7; wb_data = 8'h7E; tick();
        n_cmp++;
        if (count !== 3'd3 || pending !== 8'hD0) begin
            n_err++; $display("FAIL flush_pre: count %0d pending %h expected 3 d0", count, pending);
        end
        flush = 1'b1; commit_en = 1'b1; wb_dest = 3'd2; wb_data = 8'hEE;
        #1;
        n_cmp++;
        if (wb_ready !== 1'b0) begin
            n_err++; $display("FAIL flush_ready: got %b expected 0", wb_ready);
        end
        tick();
        flush = 1'b0; wb_valid = 1'b0;
        n_cmp++;
        if (count !== 3'd0 || pending !== 8'h00) begin
            n_err++; $display("FAIL flush_state: count %0d pending %h expected 0 00", count, pending);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (reg_at(i) !== exp_r[i]) begin
                n_err++; $display("FAIL flush_reg%0d: got %h expected %h", i, reg_at(i), exp_r[i]);
            end
        end
        wb_valid = 1'b1; wb_dest = 3'd2; wb_data = 8'h5A;
        tick();
        wb_valid = 1'b0;
        tick();
        n_cmp++;
        if (C !== 8'h5A || count !== 3'd0 || pending !== 8'h00) begin
            n_err++; $display("FAIL flush_after: C %h count %0d pending %h expected 5a 0 00",
                              C, count, pending);
        end
    endtask

    initial begin
        rst = 1'b1; wb_valid = 1'b0; wb_dest = 3'd0; wb_data = 8'h00;
        commit_en = 1'b0; flush = 1'b0;
        for (int i = 0; i < 8; i++) exp_r[i] = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_same_dest();
        test_back_to_back();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-back end of the ALU datapath. The ALU output routing delivers one result plus an 8-way destination index. This block buffers those results in a small FIFO and commits one per cycle into the eight general registers A..H.
- The eight register values drive the A/B-side operand selectors.
- Per-register pending flags let control stall reads of a register that has an uncommitted write.

Parameters:
- WORD_SIZE, 8, width of each register and result word
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- wb_valid  input  1  a result is offered this cycle
- wb_ready  output  1  block accepts the offered result this cycle
- wb_dest  input  3  destination register index, 0=A .. 7=H
- wb_data  input  WORD_SIZE  result value
- commit_en  input  1  permits retiring the FIFO head this cycle
- flush  input  1  discard all buffered, uncommitted results
- A, B, C, D, E, F, G, H  output  WORD_SIZE each  current register contents
- pending  output  8  bit i set while any buffered entry targets register i
- count  output  $clog2(DEPTH)+1  number of buffered entries

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset:
  - Registers A..H are 0.
  - count is 0; read/write pointers are 0.
  - pending is 0.
  - wb_ready is 0 while rst is high and 1 on the first cycle after release.
- Ready: wb_ready = !rst && !flush && (count < DEPTH).
  - Combinational from state and flush only; never depends on wb_valid.
  - No push when full, even if a commit happens in the same cycle.
- Push: when wb_valid && wb_ready, {wb_dest, wb_data} is written at the write pointer and the write pointer increments modulo DEPTH.
- Commit (pop): when count > 0 && commit_en && !flush, the head entry is written to register[dest] and the read pointer increments modulo DEPTH.
  - At most one commit per cycle.
- Latency:
  - A result pushed at edge N can commit at edge N+1 at the earliest.
  - Its value is visible on the output at edge N+1.
  - There is no bypass from wb_data to the register outputs.
- Simultaneous push and commit: count is unchanged and both pointers advance.
- Ordering: strict FIFO. Two entries to the same register commit in arrival order, so the last-arrived value wins.
- pending:
  - Bitwise OR, over all valid entries, of the one-hot decode of each entry's dest.
  - Computed combinationally from FIFO contents and count.
  - Clears in the same cycle the register output shows the committed value.
  - Entries accepted in the current cycle appear in pending the next cycle.
- flush:
  - Takes priority over push and commit.
  - At the next edge, count and both pointers become 0 and pending becomes 0.
  - Registers A..H are unchanged, and no commit occurs in the flush cycle.
- Empty with commit_en high: no action.
- Full with wb_valid high: the offer is held off by wb_ready=0. The producer must hold wb_dest and wb_data stable until it is accepted.
- Reset mid-operation:
  - All buffered entries are lost.
  - Registers clear to 0 asynchronously.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; full and empty are decided by count, not by pointer compare.

Decomposition:
- Shared package tau_pkg:
  - localparam WORD_SIZE default.
  - typedef reg_idx_t as 3-bit logic.
  - Enum constants REG_A..REG_H = 0..7.
  - typedef struct packed wb_entry_t {reg_idx_t dest; logic [WORD_SIZE-1:0] data;}.
- Sub-module wb_fifo:
  - Generic DEPTH-entry synchronous FIFO of wb_entry_t with push, pop, flush, count, full, empty.
  - Exposes its entry array and valid mask for the pending decode.
- Top level holds the 8-register bank, the commit write decode and the pending OR-reduction.

Test Plan:
- Reset: assert rst mid-stream with 2 entries buffered and A=0x55 → A..H=0, count=0, pending=0, wb_ready=0; after release wb_ready=1.
- Single write: push dest=3 data=0xA7 with commit_en=1 → pending[3]=1 for one cycle, then D=0xA7, pending=0, count=0.
- Back-pressure: commit_en=0, push 4 entries (dest 0,1,2,7; data 0x11,0x22,0x33,0x77) → count=4, wb_ready=0, pending=0x87; a 5th wb_valid is not accepted.
  - Then raise commit_en → A=0x11, B=0x22, C=0x33, H=0x77 on consecutive cycles, and wb_ready returns the cycle after the first commit.
- Same-destination ordering: push dest=5 data=0x01 then dest=5 data=0x02, commit_en=1 → F=0x01 then F=0x02; pending[5] stays 1 until the second commit.
- Simultaneous push and commit: count=2, push while committing → count stays 2 and the pointers wrap past DEPTH-1 correctly across 10 continuous transfers.
- Flush: 3 entries buffered, flush=1 together with wb_valid=1 and commit_en=1 → count=0, pending=0, registers unchanged, the offered result is not accepted.
